// File: rtl/seven_seg_scan_if.sv
// seven_seg_scan_if
// Groups the display-value load port and the decoder/anode outputs of the
// seven-segment scan controller.
//   enable  : 1 = scan, 0 = anodes off and scanner idle
//   load    : single-cycle strobe capturing value/dp_in into the pending buffer
//   value   : display nibbles, digit i = value[4i+3:4i], digit 0 rightmost
//   dp_in   : decimal-point flags, bit i -> digit i
//   lzb     : leading-zero blanking enable
//   hex     : nibble to the shared decoder
//   dp      : decimal-point flag to the decoder (1 = dot on)
//   anode   : active-low digit enables
//   pending : pending buffer holds a value not yet displayed
interface seven_seg_scan_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic                      enable;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic                      lzb;
    logic [3:0]                hex;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     anode;
    logic                      pending;

    modport master (
        output enable, load, value, dp_in, lzb,
        input  hex, dp, anode, pending
    );

    modport slave (
        input  enable, load, value, dp_in, lzb,
        output hex, dp, anode, pending
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
// Time-multiplexed scan controller for a bank of common-anode digits sharing
// one hex-to-7-segment decoder. Holds a double-buffered display word, steps
// through the digits one slot of REFRESH_DIV cycles at a time, and blanks all
// anodes for BLANK_CYCLES at the start of each slot to suppress ghosting.
// New values are only moved into the display buffer at the start of a frame,
// so a frame never mixes old and new digits.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : seven_seg_scan_if slave (enable/load/value/dp_in/lzb in,
//         hex/dp/anode/pending out)
//
// state  | meaning
// IDLE   | scanner stopped, all anodes off, index/slot counter at 0
// BLANK  | start of a slot, anodes off, hex/dp already show the digit
// SHOW   | current digit's anode driven low (unless leading-zero blanked)
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    seven_seg_scan_if.slave  bus
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic                    pending_q, pending_d;
    logic [3:0]              hex_q, hex_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic                    frame_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (!bus.enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                S_BLANK: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == BLANK_LAST) begin
                        state_d = S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_d = S_BLANK;
                        cnt_d   = '0;
                        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Entry into BLANK with index 0: either starting up or wrapping the frame.
    assign frame_start = bus.enable &&
                         ((state_q == S_IDLE) ||
                          (state_q == S_SHOW && cnt_q == SLOT_LAST && idx_q == IDX_LAST));

    // Transfer uses the old pending contents; a coincident load then refills
    // pending, so it wins the pending flag.
    always_comb begin
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        pending_d  = pending_q;
        if (frame_start && pending_q) begin
            disp_val_d = pend_val_q;
            disp_dp_d  = pend_dp_q;
            pending_d  = 1'b0;
        end
        if (bus.load) begin
            pend_val_d = bus.value;
            pend_dp_d  = bus.dp_in;
            pending_d  = 1'b1;
        end
    end

    // Outputs are decoded from next-state values so the registered outputs
    // line up with the state they describe.
    always_comb begin
        logic                  zero_run;
        logic [NUM_DIGITS-1:0] suppress;
        zero_run = 1'b1;
        suppress = '0;
        hex_d    = '0;
        dp_d     = 1'b0;
        anode_d  = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run && (disp_val_d[4*i +: 4] == 4'h0);
            suppress[i] = zero_run && !disp_dp_d[i] && (i != 0);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                hex_d = disp_val_d[4*i +: 4];
                dp_d  = disp_dp_d[i];
                if (state_d == S_SHOW && !(bus.lzb && suppress[i])) begin
                    anode_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            pending_q  <= 1'b0;
            hex_q      <= '0;
            dp_q       <= 1'b0;
            anode_q    <= '1;
        end else begin
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            pending_q  <= pending_d;
            hex_q      <= hex_d;
            dp_q       <= dp_d;
            anode_q    <= anode_d;
        end
    end

    assign bus.hex     = hex_q;
    assign bus.dp      = dp_q;
    assign bus.anode   = anode_q;
    assign bus.pending = pending_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl
// Self-checking bench for seven_seg_scan_ctrl with NUM_DIGITS=4,
// REFRESH_DIV=4, BLANK_CYCLES=1. A position-in-frame model predicts every
// output each cycle; directed scenarios add literal expectations, followed by
// a randomized phase.
module tb_seven_seg_scan_ctrl;
    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BC = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seven_seg_scan_if #(.NUM_DIGITS(ND)) bus ();

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(ND),
        .REFRESH_DIV(RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_disp = '0, m_pend = '0;
    logic [3:0]  m_ddp = '0, m_pdp = '0;
    bit          m_pending = 0, m_active = 0;
    int          m_pos = 0;
    bit          m_frame;
    int          m_digit;
    logic [3:0]  e_hex = '0, e_anode = 4'hF;
    logic        e_dp = 1'b0, e_pend = 1'b0;

    function automatic bit suppressed(input int d, input logic lz);
        if (!lz || d == 0 || m_ddp[d]) return 1'b0;
        return (m_disp >> (4 * d)) == 16'h0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0;
            m_pending = 0; m_active = 0; m_pos = 0;
            e_hex = '0; e_dp = 1'b0; e_anode = 4'hF; e_pend = 1'b0;
        end else begin
            m_frame = 0;
            if (!bus.enable) begin
                m_active = 0;
            end else if (!m_active) begin
                m_active = 1; m_pos = 0; m_frame = 1;
            end else begin
                m_pos   = (m_pos + 1) % (ND * RD);
                m_frame = (m_pos == 0);
            end
            if (m_frame && m_pending) begin
                m_disp = m_pend; m_ddp = m_pdp; m_pending = 0;
            end
            if (bus.load) begin
                m_pend = bus.value; m_pdp = bus.dp_in; m_pending = 1;
            end
            m_digit = m_active ? (m_pos / RD) : 0;
            e_hex   = m_disp[4*m_digit +: 4];
            e_dp    = m_ddp[m_digit];
            e_anode = 4'hF;
            if (m_active && (m_pos % RD) >= BC && !suppressed(m_digit, bus.lzb))
                e_anode[m_digit] = 1'b0;
            e_pend = m_pending;
        end
    end

    always @(negedge clk) begin
        chk("hex", 32'(bus.hex), 32'(e_hex));
        chk("dp", 32'(bus.dp), 32'(e_dp));
        chk("anode", 32'(bus.anode), 32'(e_anode));
        chk("pending", 32'(bus.pending), 32'(e_pend));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        ncyc++;
    endtask

    task automatic goto_cyc(input int n);
        while (ncyc < n) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        bus.load = 1'b1; bus.value = v; bus.dp_in = d;
        tick();
        bus.load = 1'b0;
    endtask

    initial begin
        logic [3:0] xh [4];
        logic [3:0] ea;
        logic [15:0] rv;
        xh[0] = 4'hF; xh[1] = 4'hA; xh[2] = 4'h2; xh[3] = 4'h1;
        bus.enable = 1'b0; bus.load = 1'b0; bus.value = '0;
        bus.dp_in = '0; bus.lzb = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_anode", 32'(bus.anode), 32'h0000000F);
        chk("rst_hex", 32'(bus.hex), 32'h0);
        chk("rst_pending", 32'(bus.pending), 32'h0);

        // 1: load 12AF, start scanning, check one full frame literally
        rst = 1'b0;
        bus.load = 1'b1; bus.value = 16'h12AF; bus.dp_in = 4'b0100;
        tick();
        bus.load = 1'b0; bus.enable = 1'b1;
        chk("s1_pending_rise", 32'(bus.pending), 32'h1);
        tick();
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                ea = 4'hF;
                if (j != 0) ea[k] = 1'b0;
                chk("s1_anode", 32'(bus.anode), 32'(ea));
                chk("s1_hex", 32'(bus.hex), 32'(xh[k]));
                chk("s1_dp", 32'(bus.dp), (k == 2) ? 32'h1 : 32'h0);
                tick();
            end
        end
        chk("s1_frame_period_hex", 32'(bus.hex), 32'hF);
        chk("s1_frame_period_anode", 32'(bus.anode), 32'hF);

        // 2: mid-frame load of 0000 waits for the wrap
        do_load(16'h0000, 4'b0000);
        chk("s2_pending", 32'(bus.pending), 32'h1);
        goto_cyc(33);
        chk("s2_pending_before_wrap", 32'(bus.pending), 32'h1);
        chk("s2_old_frame_hex", 32'(bus.hex), 32'h1);
        tick();
        chk("s2_pending_after_wrap", 32'(bus.pending), 32'h0);
        chk("s2_new_frame_hex", 32'(bus.hex), 32'h0);

        // 3: two loads in a frame, then a load on the wrap cycle
        goto_cyc(35); do_load(16'h1111, 4'b0000);
        goto_cyc(40); do_load(16'h2222, 4'b0000);
        goto_cyc(50);
        chk("s3_last_load_wins", 32'(bus.hex), 32'h2);
        goto_cyc(55); do_load(16'h3333, 4'b0000);
        goto_cyc(65); do_load(16'h4444, 4'b0000);
        chk("s3_wrap_old_shown", 32'(bus.hex), 32'h3);
        chk("s3_wrap_new_pending", 32'(bus.pending), 32'h1);
        goto_cyc(82);
        chk("s3_new_next_frame", 32'(bus.hex), 32'h4);
        chk("s3_pending_clear", 32'(bus.pending), 32'h0);

        // 4: leading-zero blanking
        bus.lzb = 1'b1;
        do_load(16'h0050, 4'b0000);
        goto_cyc(99);  chk("s4_0050_d0", 32'(bus.anode), 32'hE);
        goto_cyc(103); chk("s4_0050_d1", 32'(bus.anode), 32'hD);
        goto_cyc(107); chk("s4_0050_d2", 32'(bus.anode), 32'hF);
        goto_cyc(111); chk("s4_0050_d3", 32'(bus.anode), 32'hF);
        goto_cyc(112); do_load(16'h0000, 4'b0000);
        goto_cyc(115); chk("s4_zero_d0", 32'(bus.anode), 32'hE);
        goto_cyc(119); chk("s4_zero_d1", 32'(bus.anode), 32'hF);
        goto_cyc(120); do_load(16'h0000, 4'b1000);
        goto_cyc(131); chk("s4_dp_d0", 32'(bus.anode), 32'hE);
        goto_cyc(139); chk("s4_dp_d2", 32'(bus.anode), 32'hF);
        goto_cyc(143); chk("s4_dp_d3", 32'(bus.anode), 32'h7);

        // 5: drop enable during digit-2 SHOW, then re-enable
        bus.lzb = 1'b0;
        goto_cyc(155);
        chk("s5_d2_show", 32'(bus.anode), 32'hB);
        bus.enable = 1'b0;
        tick();
        chk("s5_disable_off", 32'(bus.anode), 32'hF);
        tick();
        bus.enable = 1'b1;
        tick();
        chk("s5_reenable_blank", 32'(bus.anode), 32'hF);
        tick();
        chk("s5_reenable_d0", 32'(bus.anode), 32'hE);

        // 6: asynchronous reset mid-SHOW with a pending value
        do_load(16'hABCD, 4'b0011);
        chk("s6_pending_set", 32'(bus.pending), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("s6_async_anode", 32'(bus.anode), 32'hF);
        chk("s6_async_hex", 32'(bus.hex), 32'h0);
        chk("s6_async_pending", 32'(bus.pending), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("s6_after_reset_hex", 32'(bus.hex), 32'h0);
        end

        // randomized phase, checked by the model
        for (int i = 0; i < 1500; i++) begin
            tick();
            bus.load = ($urandom_range(0, 7) == 0);
            if (bus.load) begin
                rv = 16'($urandom);
                for (int n = 0; n < 4; n++)
                    if ($urandom_range(0, 1) == 0) rv[4*n +: 4] = 4'h0;
                bus.value = rv;
                bus.dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            end
            if ($urandom_range(0, 59) == 0) bus.enable = ~bus.enable;
            if ($urandom_range(0, 99) == 0) bus.lzb = ~bus.lzb;
        end
        bus.load = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexed scan controller that shares one hex-to-7-segment decoder across a bank of common-anode digits. It holds a double-buffered display word and steps through the digits at a fixed refresh rate. For each digit slot it presents that digit's nibble and decimal-point flag to the decoder and drives the matching active-low anode. It inserts a blanking gap before each digit to suppress ghosting. It sits between the register/control logic that produces display values and the board-level `HexTo7Segment` decoder and anode pins.

## Interface
- `NUM_DIGITS`, 4, number of digits scanned (2..8)
- `REFRESH_DIV`, 50000, clock cycles per digit slot (≥2)
- `BLANK_CYCLES`, 2, cycles at the start of each slot with all anodes off (1..REFRESH_DIV-1)
- `Clk`  in  1  system clock; all state updates on rising edge
- `Reset`  in  1  asynchronous, active-high reset
- `Enable`  in  1  1 = scan, 0 = all anodes off, scanner idle
- `Load`  in  1  single-cycle strobe; captures `Value`/`DPIn` into the pending buffer
- `Value`  in  4*NUM_DIGITS  display nibbles; digit i = `Value[4i+3:4i]`, digit 0 rightmost
- `DPIn`  in  NUM_DIGITS  decimal-point-on flags, bit i → digit i
- `LZB`  in  1  leading-zero blanking enable
- `Hex`  out  4  nibble to the decoder
- `DP`  out  1  decimal-point flag to the decoder (1 = dot on)
- `Anode`  out  NUM_DIGITS  active-low digit enables; at most one bit low
- `Pending`  out  1  pending buffer holds a value not yet displayed

## Operation
- Registers:
  - pending buffer (`PendVal`, `PendDP`, `Pending`)
  - display buffer (`DispVal`, `DispDP`)
  - digit index (`$clog2(NUM_DIGITS)` bits)
  - slot counter (`$clog2(REFRESH_DIV)` bits)
  - state
- States:
  - IDLE: anodes all 1; slot counter and index held at 0.
  - BLANK: anodes all 1; `Hex`/`DP` already show the current digit.
  - SHOW: the current digit's anode is 0.
- Transitions:
  - IDLE→BLANK (index 0) when `Enable`=1.
  - BLANK→SHOW when slot counter = BLANK_CYCLES-1.
  - SHOW→BLANK when slot counter = REFRESH_DIV-1. The index increments, wrapping from NUM_DIGITS-1 to 0, and the slot counter returns to 0.
  - Any state→IDLE when `Enable`=0. This takes priority over all other transitions.
- Load: on `Load`=1, `PendVal`←`Value`, `PendDP`←`DPIn`, `Pending`←1. A Load while `Pending`=1 overwrites the pending buffer.
- Frame-boundary transfer happens only on entry to BLANK with index 0 (from IDLE or on wrap):
  - If `Pending`=1: `DispVal`←`PendVal`, `DispDP`←`PendDP`, and `Pending`←0.
  - If `Load` arrives in the same cycle, the old pending value transfers, the new value enters pending, and `Pending` stays 1.
- This gives tear-free updates: a frame never mixes old and new values.
- `Hex` = `DispVal` nibble at the current index; `DP` = `DispDP` bit at the current index. Both are registered.
- Leading-zero blanking: when `LZB`=1, digit i (i>0) is suppressed if it and every higher digit are zero in `DispVal`. A suppressed digit keeps its anode high during SHOW, but timing is unchanged. Digit 0 is never suppressed. A set DP bit on digit i prevents suppression of digit i.
- Reset values: state IDLE, index 0, slot counter 0, `Anode` all 1, `Hex`=0, `DP`=0, `DispVal`/`PendVal`=0, `DispDP`/`PendDP`=0, `Pending`=0.

## Timing
- All outputs are registered, so each reflects the state one cycle after the causing edge.
- `Anode` goes low exactly BLANK_CYCLES cycles after `Hex` changes to a new digit.
- `Anode` goes high on the cycle after the last SHOW cycle.
- Slot period = REFRESH_DIV cycles; frame period = NUM_DIGITS*REFRESH_DIV cycles.
- Digit 0 is on for REFRESH_DIV-BLANK_CYCLES cycles per frame.
- `Pending` rises the cycle after `Load`.
- `Pending` falls the cycle after a frame-boundary transfer. Worst-case Load-to-display latency is one frame plus BLANK_CYCLES+1 cycles.
- `Enable` falling: `Anode` is all 1 on the next cycle. `Enable` rising: the first digit-0 anode goes low BLANK_CYCLES+1 cycles later.
- `Reset` asserted mid-scan forces all reset values immediately, without waiting for a clock edge. The pending value is lost.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.

1. Reset then `Enable`=1, `Load` `Value`=16'h12AF, `DPIn`=4'b0100 → after transfer, digits 0..3 show `Hex`=F,A,2,1 in sequence.
   - `DP`=1 only during digit 2.
   - `Anode` sequence per slot: 1111 for 1 cycle, then 1110/1101/1011/0111 for 3 cycles.
   - 16-cycle frame.
2. Mid-frame `Load` 16'h0000 while displaying 16'h12AF → the current frame completes with 12AF.
   - The next frame starts with 0000.
   - `Pending` stays 1 from the Load until the cycle after the wrap.
3. Two `Load`s in one frame (16'h1111 then 16'h2222) → only 2222 is ever displayed; 1111 never appears.
   - `Load` coinciding with the wrap cycle → the old pending value is shown and the new one stays pending.
4. `LZB`=1, `Value`=16'h0050 → digits 3 and 2 keep `Anode` high during their SHOW cycles; digits 1 and 0 light.
   - `Value`=16'h0000 → only digit 0 lights.
   - `DPIn`=4'b1000 with 16'h0000 → digits 3 and 0 light.
5. Drop `Enable` during digit-2 SHOW → `Anode`=1111 on the next cycle and the index resets to 0.
   - Re-enable → digit 0 lights 2 cycles later.
6. Assert `Reset` mid-SHOW with `Pending`=1 → `Anode`=1111, `Hex`=0, `Pending`=0, asynchronously.
   - After release with `Enable`=1 → `Hex`=0 displayed on all digits.
